// File: rtl/io_uart_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : io_uart_responder                                             |
// | Purpose  : UART peripheral on the J1 IO bus. Decodes io_rd/io_wr against |
// |            mem_addr, transmits written bytes, buffers received bytes in  |
// |            a small FIFO and returns data/status on a registered io_din.  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module io_uart_responder #(
  parameter int CLKS_PER_BIT = 104,
  parameter int RX_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [15:0] mem_addr,
  input  logic [15:0] dout,
  output logic [15:0] io_din,
  input  logic        uart_rx,
  output logic        uart_tx
);

  // Bit-period counter must hold CLKS_PER_BIT-1; FIFO count must hold RX_DEPTH.
  localparam int              c_CW       = $clog2(CLKS_PER_BIT + 1);
  localparam int              c_PW       = $clog2(RX_DEPTH);
  localparam int              c_NW       = c_PW + 1;
  localparam logic [c_CW-1:0] c_BIT_LAST = c_CW'(CLKS_PER_BIT - 1);
  localparam logic [c_CW-1:0] c_HALF     = c_CW'(CLKS_PER_BIT / 2);
  localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
  localparam logic [c_NW-1:0] c_FULL     = c_NW'(RX_DEPTH);
  localparam logic [c_NW-1:0] c_NUM_ONE  = c_NW'(1);
  localparam logic [c_PW-1:0] c_PTR_ONE  = c_PW'(1);

  // ---------------------------------------------------------------- decode
  logic w_wr_data;
  logic w_rd_data;
  logic w_rd_stat;
  logic w_unused_bits;

  // Bit 12 (DATA) wins over bit 13 (STATUS) on reads.
  assign w_wr_data     = io_wr & mem_addr[12];
  assign w_rd_data     = io_rd & mem_addr[12];
  assign w_rd_stat     = io_rd & ~mem_addr[12] & mem_addr[13];
  assign w_unused_bits = ^{mem_addr[15:14], mem_addr[11:0], dout[15:8]};

  // ---------------------------------------------------------------- transmitter
  typedef enum logic [0:0] {
    TX_IDLE  = 1'b0,
    TX_SHIFT = 1'b1
  } tx_state_t;

  tx_state_t       r_tx_state;
  tx_state_t       w_tx_next;
  logic [c_CW-1:0] r_tx_cnt;
  logic [3:0]      r_tx_slot;
  logic [8:0]      r_tx_sr;     // bits still to send after the start bit: {stop, data}
  logic            r_tx;
  logic            w_tx_ready;
  logic            w_tx_start;
  logic            w_tx_tick;

  assign w_tx_ready = (r_tx_state == TX_IDLE);
  assign w_tx_start = w_wr_data & w_tx_ready;
  assign w_tx_tick  = (r_tx_cnt == '0);

  // TX state register
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) r_tx_state <= TX_IDLE;
    else         r_tx_state <= w_tx_next;
  end

  // TX next state: leave SHIFT at the end of the tenth bit slot
  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      TX_IDLE:  if (w_tx_start) w_tx_next = TX_SHIFT;
      TX_SHIFT: if (w_tx_tick && (r_tx_slot == 4'd0)) w_tx_next = TX_IDLE;
      default:  w_tx_next = TX_IDLE;
    endcase
  end

  // TX datapath: start bit driven at load, then one shift per bit period
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_tx_cnt  <= '0;
      r_tx_slot <= '0;
      r_tx_sr   <= '1;
      r_tx      <= 1'b1;
    end else if (r_tx_state == TX_IDLE) begin
      if (w_tx_start) begin
        r_tx_sr   <= {1'b1, dout[7:0]};
        r_tx      <= 1'b0;
        r_tx_cnt  <= c_BIT_LAST;
        r_tx_slot <= 4'd9;
      end
    end else if (w_tx_tick) begin
      if (r_tx_slot == 4'd0) begin
        r_tx <= 1'b1;
      end else begin
        r_tx      <= r_tx_sr[0];
        r_tx_sr   <= {1'b1, r_tx_sr[8:1]};
        r_tx_slot <= r_tx_slot - 4'd1;
        r_tx_cnt  <= c_BIT_LAST;
      end
    end else begin
      r_tx_cnt <= r_tx_cnt - c_CNT_ONE;
    end
  end

  assign uart_tx = r_tx;

  // ---------------------------------------------------------------- receiver
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  logic            r_rx_s1;
  logic            r_rx_s2;
  logic            r_rx_prev;
  rx_state_t       r_rx_state;
  rx_state_t       w_rx_next;
  logic [c_CW-1:0] r_rx_cnt;
  logic [2:0]      r_rx_bit;
  logic [7:0]      r_rx_sr;
  logic            w_rx_fall;
  logic            w_rx_tick;
  logic            w_rx_push;

  assign w_rx_fall = r_rx_prev & ~r_rx_s2;
  assign w_rx_tick = (r_rx_cnt == '0);
  assign w_rx_push = (r_rx_state == RX_STOP) & w_rx_tick & r_rx_s2;

  // Two-flop synchroniser plus one delayed copy for edge detection
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= uart_rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  // RX state register
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) r_rx_state <= RX_IDLE;
    else         r_rx_state <= w_rx_next;
  end

  // RX next state: a high line at the start-bit sample is a false start
  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE:  if (w_rx_fall) w_rx_next = RX_START;
      RX_START: if (w_rx_tick) w_rx_next = r_rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_rx_tick && (r_rx_bit == 3'd7)) w_rx_next = RX_STOP;
      RX_STOP:  if (w_rx_tick) w_rx_next = RX_IDLE;
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  // RX datapath: half-bit alignment, then one sample per bit period, LSB first
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_rx_cnt <= '0;
      r_rx_bit <= '0;
      r_rx_sr  <= '0;
    end else begin
      case (r_rx_state)
        RX_IDLE: begin
          if (w_rx_fall) r_rx_cnt <= c_HALF;
        end
        RX_START: begin
          if (w_rx_tick) begin
            r_rx_cnt <= c_BIT_LAST;
            r_rx_bit <= 3'd0;
          end else begin
            r_rx_cnt <= r_rx_cnt - c_CNT_ONE;
          end
        end
        RX_DATA: begin
          if (w_rx_tick) begin
            r_rx_sr  <= {r_rx_s2, r_rx_sr[7:1]};
            r_rx_bit <= r_rx_bit + 3'd1;
            r_rx_cnt <= c_BIT_LAST;
          end else begin
            r_rx_cnt <= r_rx_cnt - c_CNT_ONE;
          end
        end
        default: begin
          if (!w_rx_tick) r_rx_cnt <= r_rx_cnt - c_CNT_ONE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- receive FIFO
  logic [7:0]      r_fifo [RX_DEPTH];
  logic [c_PW-1:0] r_wr_ptr;
  logic [c_PW-1:0] r_rd_ptr;
  logic [c_NW-1:0] r_count;
  logic            r_overrun;
  logic            w_full;
  logic            w_avail;
  logic            w_pop;
  logic            w_push;
  logic            w_ovr_set;

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign w_full    = (r_count == c_FULL);
  assign w_avail   = (r_count != '0);
  assign w_pop     = w_rd_data & w_avail;
  assign w_push    = w_rx_push & (~w_full | w_pop);
  assign w_ovr_set = w_rx_push & w_full & ~w_pop;

  generate
    for (genvar gi = 0; gi < RX_DEPTH; gi++) begin : g_fifo_entry
      // Storage entry, written when the write pointer selects it
      always_ff @(posedge clk or negedge resetq) begin
        if (!resetq)                                r_fifo[gi] <= 8'h00;
        else if (w_push && (r_wr_ptr == c_PW'(gi))) r_fifo[gi] <= r_rx_sr;
      end
    end
  endgenerate

  // Pointers wrap naturally because the depth is a power of two
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_NUM_ONE;
        2'b01:   r_count <= r_count - c_NUM_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overrun; a new overrun beats a simultaneous status-read clear
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq)        r_overrun <= 1'b0;
    else if (w_ovr_set) r_overrun <= 1'b1;
    else if (w_rd_stat) r_overrun <= 1'b0;
  end

  // ---------------------------------------------------------------- read data
  logic [15:0] r_io_din;

  // Registered read data, held between read strobes
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_io_din <= 16'h0000;
    end else if (io_rd) begin
      if (mem_addr[12])      r_io_din <= w_avail ? {8'h00, r_fifo[r_rd_ptr]} : 16'h0000;
      else if (mem_addr[13]) r_io_din <= {13'd0, r_overrun, w_tx_ready, w_avail};
      else                   r_io_din <= 16'h0000;
    end
  end

  assign io_din = r_io_din;

endmodule
`default_nettype wire

// File: tb/tb_io_uart_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_io_uart_responder                                          |
// | Purpose  : Self-checking bench for io_uart_responder with a queue-based  |
// |            reference model of the receive FIFO and overrun flag.        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_io_uart_responder;

  localparam int C     = 8;
  localparam int DEPTH = 4;

  logic        clk      = 1'b0;
  logic        resetq   = 1'b0;
  logic        io_rd    = 1'b0;
  logic        io_wr    = 1'b0;
  logic [15:0] mem_addr = 16'h0000;
  logic [15:0] dout     = 16'h0000;
  logic        uart_rx  = 1'b1;
  logic [15:0] io_din;
  logic        uart_tx;

  int checks = 0;
  int errors = 0;

  // Reference model: received bytes in arrival order, plus the sticky overrun.
  logic [7:0]  q[$];
  bit          ovr = 1'b0;
  logic [15:0] last_exp = 16'h0000;

  always #5 clk = ~clk;

  io_uart_responder #(.CLKS_PER_BIT(C), .RX_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .resetq   (resetq),
    .io_rd    (io_rd),
    .io_wr    (io_wr),
    .mem_addr (mem_addr),
    .dout     (dout),
    .io_din   (io_din),
    .uart_rx  (uart_rx),
    .uart_tx  (uart_tx)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void m_push(input logic [7:0] b);
    if (q.size() == DEPTH) ovr = 1'b1;
    else                   q.push_back(b);
  endfunction

  function automatic logic [15:0] m_data();
    if (q.size() == 0) return 16'h0000;
    return {8'h00, q.pop_front()};
  endfunction

  function automatic logic [15:0] m_status(input bit tx_ready);
    logic [15:0] s;
    s   = {13'd0, ovr, tx_ready, (q.size() != 0)};
    ovr = 1'b0;
    return s;
  endfunction

  task automatic rd(input logic [15:0] a, output logic [15:0] d);
    @(negedge clk);
    mem_addr = a;
    io_rd    = 1'b1;
    @(negedge clk);
    io_rd = 1'b0;
    d     = io_din;
  endtask

  task automatic rd_data_chk(input string tag);
    logic [15:0] d, e;
    e = m_data();
    rd(16'h1000, d);
    check(tag, d, e);
    last_exp = e;
  endtask

  task automatic rd_stat_chk(input string tag);
    logic [15:0] d, e;
    e = m_status(1'b1);
    rd(16'h2000, d);
    check(tag, d, e);
    last_exp = e;
  endtask

  // Drive one serial frame starting at cycle t=0; optionally strobe a data read at pop_at.
  task automatic rx_frame(input logic [7:0] b, input bit stop, input int pop_at,
                          output logic [15:0] popped);
    logic [9:0] fr;
    fr     = {stop, b, 1'b0};
    popped = 16'h0000;
    for (int t = 0; t <= 10 * C + 1; t++) begin
      @(negedge clk);
      if (t == pop_at + 1) begin
        io_rd  = 1'b0;
        popped = io_din;
      end
      uart_rx = (t < 10 * C) ? fr[t / C] : 1'b1;
      if (t == pop_at) begin
        mem_addr = 16'h1000;
        io_rd    = 1'b1;
      end
    end
  endtask

  // Write a byte (with a simultaneous data read) and check the serial waveform.
  task automatic tx_frame(input logic [7:0] d, input bit probe);
    logic [9:0]  fr;
    logic [15:0] e, e2;
    fr = {1'b1, d, 1'b0};
    @(negedge clk);
    mem_addr = 16'h3000;
    dout     = {8'h5A, d};
    io_wr    = 1'b1;
    io_rd    = 1'b1;
    e        = m_data();
    for (int t = 1; t <= 10 * C; t++) begin
      @(negedge clk);
      if (t == 1) begin
        io_wr = 1'b0;
        io_rd = 1'b0;
        check("rd_with_wr", io_din, e);
      end
      check("tx_bit", {15'd0, uart_tx}, {15'd0, fr[(t - 1) / C]});
      if (probe && t == 40) begin
        dout  = 16'h00FF;
        io_wr = 1'b1;
      end
      if (probe && t == 41) io_wr = 1'b0;
      if (probe && t == 10 * C) begin
        mem_addr = 16'h2000;
        io_rd    = 1'b1;
        e        = m_status(1'b0);
      end
    end
    if (probe) begin
      @(negedge clk);
      check("tx_busy_last_cycle", io_din, e);
      e2 = m_status(1'b1);
      @(negedge clk);
      io_rd = 1'b0;
      check("tx_ready_after_frame", io_din, e2);
      check("tx_line_idle", {15'd0, uart_tx}, 16'h0001);
      last_exp = e2;
    end
  endtask

  initial begin
    logic [15:0] d, p, e;
    logic [7:0]  b;
    bit          stop;
    int          n;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_io_din", io_din, 16'h0000);
    check("reset_uart_tx", {15'd0, uart_tx}, 16'h0001);
    resetq = 1'b1;
    rd_stat_chk("status_after_reset");
    check("tx_idle_after_reset", {15'd0, uart_tx}, 16'h0001);

    // Transmit 0xA5 with a dropped write mid-frame
    tx_frame(8'hA5, 1'b1);

    // Write with bit 12 clear is ignored
    @(negedge clk);
    mem_addr = 16'h2000;
    dout     = 16'h0055;
    io_wr    = 1'b1;
    @(negedge clk);
    io_wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ignored_write_line", {15'd0, uart_tx}, 16'h0001);
    end
    rd_stat_chk("ignored_write_status");

    // Single received byte
    rx_frame(8'h3C, 1'b1, -5, p);
    m_push(8'h3C);
    rd_stat_chk("status_rx_avail");
    rd_data_chk("data_3c");
    rd_stat_chk("status_after_pop");
    repeat (3) @(negedge clk);
    check("din_hold", io_din, last_exp);
    rd(16'h0400, d);
    check("unmapped_read", d, 16'h0000);

    // Overrun: five bytes into a four-deep FIFO
    for (int i = 1; i <= 5; i++) begin
      rx_frame(8'(i), 1'b1, -5, p);
      m_push(8'(i));
    end
    rd_stat_chk("status_overrun");
    for (int i = 0; i < 5; i++) rd_data_chk("drain_after_overrun");
    rd_stat_chk("status_overrun_cleared");

    // Short glitch and framing error
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (C / 4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (12 * C) @(negedge clk);
    rd_stat_chk("status_after_glitch");
    rx_frame(8'h99, 1'b0, -5, p);
    repeat (2 * C) @(negedge clk);
    rd_stat_chk("status_after_framing");
    rd_data_chk("data_after_framing");

    // Full FIFO: pop coincides with push
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom_range(1, 255));
      rx_frame(b, 1'b1, -5, p);
      m_push(b);
    end
    b = 8'($urandom_range(1, 255));
    e = m_data();
    rx_frame(b, 1'b1, 10 * C - 1, p);
    m_push(b);
    check("full_push_pop_read", p, e);
    rd_stat_chk("full_push_pop_status");
    for (int i = 0; i < DEPTH; i++) rd_data_chk("drain_after_full_push_pop");
    rd_data_chk("empty_after_drain");

    // Empty FIFO: pop returns zero, pushed byte retained
    b = 8'($urandom_range(1, 255));
    e = m_data();
    rx_frame(b, 1'b1, 10 * C - 1, p);
    m_push(b);
    check("empty_push_pop_read", p, e);
    rd_data_chk("empty_push_retained");

    // Back-to-back transmit frames
    tx_frame(8'($urandom_range(0, 255)), 1'b0);
    tx_frame(8'($urandom_range(0, 255)), 1'b1);

    // Randomized traffic
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        b    = 8'($urandom_range(0, 255));
        stop = ($urandom_range(0, 3) != 0);
        rx_frame(b, stop, -5, p);
        if (stop) m_push(b);
      end
      n = $urandom_range(0, 5);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 2) == 0) rd_stat_chk("rand_status");
        else                           rd_data_chk("rand_data");
      end
      if ($urandom_range(0, 1) == 1) tx_frame(8'($urandom_range(0, 255)), 1'b0);
      rd_stat_chk("rand_round_status");
    end

    // Asynchronous reset in the middle of a transmit frame
    rx_frame(8'h42, 1'b1, -5, p);
    m_push(8'h42);
    rd_stat_chk("status_before_reset");
    @(negedge clk);
    mem_addr = 16'h1000;
    dout     = 16'h0000;
    io_wr    = 1'b1;
    @(negedge clk);
    io_wr = 1'b0;
    @(negedge clk);
    check("tx_start_bit_before_reset", {15'd0, uart_tx}, 16'h0000);
    #2;
    resetq = 1'b0;
    #1;
    check("async_reset_uart_tx", {15'd0, uart_tx}, 16'h0001);
    check("async_reset_io_din", io_din, 16'h0000);
    q.delete();
    ovr = 1'b0;
    @(negedge clk);
    resetq = 1'b1;
    rd_stat_chk("status_after_async_reset");
    rd_data_chk("fifo_empty_after_async_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/io_uart_responder.md
# io_uart_responder

UART peripheral answering the J1 core's IO bus: it decodes `io_rd`/`io_wr` strobes against `mem_addr`, accepts bytes for serial transmission, and returns received bytes and status on `io_din`. It is the responder end of the core's IO read/write protocol and sits beside the core in the top level, wired straight to the serial pins. It contains a 4-deep receive FIFO, a one-byte transmit shifter and a registered read-data path.

## Interface
- `CLKS_PER_BIT`, 104, clock cycles per serial bit (12 MHz / 115200); legal range 4..65535.
- `RX_DEPTH`, 4, receive FIFO depth in bytes; power of two, ≥2.

- `clk`  in  1  system clock, rising edge.
- `resetq`  in  1  asynchronous active-low reset.
- `io_rd`  in  1  IO read strobe from the core, one cycle.
- `io_wr`  in  1  IO write strobe from the core, one cycle.
- `mem_addr`  in  16  IO address; bit 12 selects DATA, bit 13 selects STATUS.
- `dout`  in  16  write data from the core; bits 7:0 used.
- `io_din`  out  16  registered read data to the core.
- `uart_rx`  in  1  serial input, asynchronous, idle high.
- `uart_tx`  out  1  serial output, idle high.

## Operation
- Reset: `io_din`=0x0000, `uart_tx`=1, FIFO empty, overrun=0, TX idle, RX idle, synchroniser flops=1.
- Write, `io_wr`=1 and `mem_addr[12]`=1: if TX idle, load `dout[7:0]` and start a frame; if TX busy, the write is dropped. Writes with bit 12 clear are ignored.
- Read, `io_rd`=1:
  - `mem_addr[12]`=1 (takes priority over bit 13): `io_din` ← {8'h00, FIFO head}, pop one entry. If the FIFO is empty, `io_din` ← 0x0000 and nothing is popped.
  - else `mem_addr[13]`=1: `io_din` ← {13'b0, overrun, tx_ready, rx_avail}, and overrun is cleared at the same edge.
  - else: `io_din` ← 0x0000.
- Without `io_rd`, `io_din` holds its last value.
- `io_rd` and `io_wr` in the same cycle: both are processed independently.
- TX frame: start bit 0, 8 data bits LSB first, stop bit 1; each bit lasts `CLKS_PER_BIT` cycles. States: IDLE → SHIFT (10 bit slots, down-counter) → IDLE. `tx_ready`=1 only in IDLE.
- RX:
  - `uart_rx` passes through a 2-flop synchroniser.
  - States: IDLE → START → DATA → STOP → IDLE.
  - IDLE→START on a synchronised 1→0 transition.
  - START samples at `CLKS_PER_BIT/2` (integer division). If the line is high there, the start is false: return to IDLE and push nothing.
  - DATA samples 8 bits, each `CLKS_PER_BIT` after the previous sample, LSB first.
  - STOP samples once more. If 1, push the byte. If 0 (framing error), discard the byte with no flag. Return to IDLE either way.
- FIFO:
  - Push when full: byte dropped, overrun←1 (sticky).
  - Push and pop in the same cycle: both happen and the count is unchanged, including when full (no overrun) and when empty (the pop returns 0x0000; the pushed byte is retained).
  - Read/write pointers wrap modulo `RX_DEPTH`. `rx_avail` = count≠0.
- If overrun set and status-read clear coincide, set wins.

## Timing
- Read latency 1: strobe in cycle N, value on `io_din` throughout cycle N+1 and held afterwards. FIFO pop and overrun clear take effect at the edge ending cycle N.
- TX: write sampled at the edge ending cycle N.
  - `uart_tx` goes 0 from cycle N+1.
  - Data bit k starts at N+1+(k+1)·C, where C=`CLKS_PER_BIT`.
  - Stop bit is held high through N+10·C.
  - `tx_ready` is 0 in cycles N+1..N+10·C and 1 from N+10·C+1.
  - A write at N+10·C+1 starts the next frame with no gap.
- RX: the synchronised falling edge lags the pin by 2 cycles.
  - Byte pushed at the stop-bit sample point, ~9.5·C+3 cycles after the pin edge.
  - `rx_avail` visible to a status read issued the following cycle.
- RX returns to IDLE right after the stop-bit sample, so back-to-back frames with a nominal stop bit are received.
- Asynchronous reset mid-frame: `uart_tx` goes to 1 immediately, all state is cleared, and the partial RX byte is lost.

## Test plan
- Reset, then status read (`mem_addr`=0x2000) → `io_din`=0x0002 one cycle after the strobe; `uart_tx`=1.
- C=8, write 0x00A5 to 0x1000 → `uart_tx` low for 8 cycles, then 1,0,1,0,0,1,0,1 at 8 cycles each, then high. `tx_ready`=0 until cycle 81 after the write. A second write at cycle 40 is dropped (no second frame).
- Drive serial 0x3C on `uart_rx` → status=0x0003. Data read → `io_din`=0x003C, after which status=0x0002.
- Send 5 bytes 0x01..0x05 with no reads → status=0x0007. Four data reads return 0x0001..0x0004; the fifth read returns 0x0000. The status read clears overrun: the next status is 0x0002.
- Line glitch low for C/4 cycles → no push, status=0x0002. A frame with stop bit 0 → discarded, status=0x0002.
- FIFO full and a data read in the same cycle as a push → read returns the oldest byte, no overrun, count stays 4. Assert `resetq`=0 mid-TX frame → `uart_tx`=1 and `io_din`=0 immediately.
